gf180mcu_fd_sc_mcu7t5v0__nor3_idle_qual: RTL

//  Clocked qualifier stage placed directly downstream of the 3-input NOR (nor3) function.
//  - Synchronises three asynchronous activity inputs A1..A3 and forms their NOR.
//  - Requires the all-low condition to hold for SETTLE_CYC clocks before raising REQ.
//  - On ACK, enters IDLE and asserts ZN. ZN is the glitch-free, registered equivalent of
//    NOR(A1,A2,A3), consumed by clock-gate and power-down control.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__idle_pkg.sv | 15 +
 rtl/gf180mcu_fd_sc_mcu7t5v0__sync_rn.sv | 30 +++
 rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_idle_qual.sv | 110 +++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__idle_pkg.sv
// Shared types and defaults for the nor3 idle qualifier.
// Holds the FSM state encoding and default parameter values.
package gf180mcu_fd_sc_mcu7t5v0__idle_pkg;

    typedef enum logic [1:0] {
        S_ACTIVE = 2'b00,
        S_SETTLE = 2'b01,
        S_REQ    = 2'b10,
        S_IDLE   = 2'b11
    } idle_state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int SETTLE_CYC_DEF  = 8;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__sync_rn.sv
// Multi-bit flop synchroniser with asynchronous active-low reset.
// Each bit is synchronised independently through STAGES flops.
module gf180mcu_fd_sc_mcu7t5v0__sync_rn #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] ff [STAGES];

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            for (int i = 0; i < STAGES; i++) begin
                ff[i] <= '0;
            end
        end else begin
            ff[0] <= D;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign Q = ff[STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_idle_qual.sv
// Registered, settle-qualified NOR of three async activity inputs.
// Raises REQ after a quiet period; enters IDLE (ZN=1) on ACK.
module gf180mcu_fd_sc_mcu7t5v0__nor3_idle_qual
    import gf180mcu_fd_sc_mcu7t5v0__idle_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF
) (
    input  logic CLK,
    input  logic RN,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic ACK,
    output logic REQ,
    output logic ZN,
    inout  wire  VDD,
    inout  wire  VSS
);

    localparam int CNT_W = $clog2(SETTLE_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    logic [2:0]             a_s;
    logic                   nor_s;
    logic [SYNC_STAGES-1:0] prime;
    logic                   primed;
    idle_state_t            state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;

    wire pwr_unused = VDD & VSS;

    gf180mcu_fd_sc_mcu7t5v0__sync_rn #(
        .WIDTH  (3),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK (CLK),
        .RN  (RN),
        .D   ({A3, A2, A1}),
        .Q   (a_s)
    );

    assign nor_s = ~|a_s;

    // Reset-zeroed sync flops do not yet reflect the real inputs, so
    // settling starts only once every stage has sampled them.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            prime <= '0;
        end else begin
            prime <= {prime[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign primed = prime[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= S_ACTIVE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            S_ACTIVE: begin
                if (nor_s && primed) begin
                    state_n = S_SETTLE;
                    cnt_n   = '0;
                end
            end
            S_SETTLE: begin
                if (!nor_s) begin
                    state_n = S_ACTIVE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = S_REQ;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            // Activity wins over a simultaneous ACK.
            S_REQ: begin
                if (!nor_s) begin
                    state_n = S_ACTIVE;
                end else if (ACK) begin
                    state_n = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!nor_s) begin
                    state_n = S_ACTIVE;
                end
            end
            default: begin
                state_n = S_ACTIVE;
                cnt_n   = '0;
            end
        endcase
    end

    assign REQ = (state == S_REQ);
    assign ZN  = (state == S_IDLE);

endmodule
